// File: rtl/cte_color_transform.sv
// Packed 4:2:2 YUV byte stream <-> 24-bit RGB pixel converter.
// Mode 0 decodes U,Y0,V,Y1 into two RGB pixels; mode 1 encodes pixel pairs into the byte stream.
//
// phase | meaning (mode 0)              | meaning (mode 1)
// 0     | expecting U                   | expecting even pixel
// 1     | expecting Y0                  | expecting odd pixel
// 2     | expecting V, emit pixel 2k    | -
// 3     | expecting Y1, emit pixel 2k+1 | -
module cte_color_transform (
   input  logic        clk,
   input  logic        reset,
   input  logic        op_mode,
   input  logic        in_en,
   input  logic [7:0]  yuv_in,
   input  logic [23:0] rgb_in,
   output logic        busy,
   output logic        out_valid,
   output logic [23:0] rgb_out,
   output logic [7:0]  yuv_out
);

   // Round-to-nearest (ties away from zero) of n/1000; n/1000 via exact reciprocal multiply for |n| < 2^20.
   function automatic logic signed [10:0] rdiv1000(input logic signed [20:0] n);
      logic [19:0] a;
      logic [10:0] q;
      a = 20'(n[20] ? -n : n) + 20'd500;
      q = 11'(({21'd0, a} * 41'd1073742) >> 30);
      return n[20] ? -$signed(q) : $signed(q);
   endfunction

   function automatic logic [7:0] clip_u8(input logic signed [10:0] v);
      if (v < 11'sd0)        return 8'h00;
      else if (v > 11'sd255) return 8'hFF;
      else                   return v[7:0];
   endfunction

   function automatic logic [7:0] clip_s8(input logic signed [10:0] v);
      if (v < -11'sd128)     return 8'h80;
      else if (v > 11'sd127) return 8'h7F;
      else                   return v[7:0];
   endfunction

   logic [1:0]  phase_q, phase_d;
   logic        mode_q, mode_d;
   logic        pend_q, pend_d;
   logic [7:0]  u_q, u_d;
   logic [7:0]  v_q, v_d;
   logic [7:0]  y0_q, y0_d;
   logic        out_valid_q, out_valid_d;
   logic [23:0] rgb_out_q, rgb_out_d;
   logic [7:0]  yuv_out_q, yuv_out_d;

   logic [1:0]         ph;
   logic [7:0]         y_sel, v_sel;
   logic signed [20:0] ys, us, vs, rs, gs, bs;
   logic signed [20:0] r_n, g_n, b_n, ey_n, eu_n, ev_n;
   logic [23:0]        rgb_px;
   logic [7:0]         enc_y, enc_u, enc_v;

   always_comb begin
      // Any mode change restarts the group at phase 0.
      ph    = (op_mode != mode_q) ? 2'd0 : phase_q;
      y_sel = (ph == 2'd2) ? y0_q : yuv_in;
      v_sel = (ph == 2'd2) ? yuv_in : v_q;
      ys    = {13'd0, y_sel};
      us    = {{13{u_q[7]}}, u_q};
      vs    = {{13{v_sel[7]}}, v_sel};
      r_n   = 21'sd1000 * ys + 21'sd1402 * vs;
      g_n   = 21'sd1000 * ys - 21'sd344 * us - 21'sd714 * vs;
      b_n   = 21'sd1000 * ys + 21'sd1772 * us;
      rgb_px = {clip_u8(rdiv1000(r_n)), clip_u8(rdiv1000(g_n)), clip_u8(rdiv1000(b_n))};

      rs    = {13'd0, rgb_in[23:16]};
      gs    = {13'd0, rgb_in[15:8]};
      bs    = {13'd0, rgb_in[7:0]};
      ey_n  = 21'sd299 * rs + 21'sd587 * gs + 21'sd114 * bs;
      eu_n  = 21'sd500 * bs - 21'sd169 * rs - 21'sd331 * gs;
      ev_n  = 21'sd500 * rs - 21'sd419 * gs - 21'sd81 * bs;
      enc_y = clip_u8(rdiv1000(ey_n));
      enc_u = clip_s8(rdiv1000(eu_n));
      enc_v = clip_s8(rdiv1000(ev_n));
   end

   always_comb begin
      phase_d     = ph;
      mode_d      = op_mode;
      pend_d      = 1'b0;
      u_d         = u_q;
      v_d         = v_q;
      y0_d        = y0_q;
      out_valid_d = 1'b0;
      rgb_out_d   = rgb_out_q;
      yuv_out_d   = yuv_out_q;
      if (!op_mode) begin
         if (in_en) begin
            phase_d = ph + 2'd1;
            case (ph)
               2'd0: u_d  = yuv_in;
               2'd1: y0_d = yuv_in;
               2'd2: begin
                  v_d         = yuv_in;
                  rgb_out_d   = rgb_px;
                  out_valid_d = 1'b1;
               end
               default: begin
                  rgb_out_d   = rgb_px;
                  out_valid_d = 1'b1;
               end
            endcase
         end
      end else if (pend_q) begin
         yuv_out_d   = y0_q;
         out_valid_d = 1'b1;
      end else if (in_en) begin
         // y0_q holds the pending luma byte; v_q holds V of the even pixel until the odd one arrives.
         out_valid_d = 1'b1;
         pend_d      = 1'b1;
         y0_d        = enc_y;
         phase_d     = {1'b0, ~ph[0]};
         if (!ph[0]) begin
            yuv_out_d = enc_u;
            v_d       = enc_v;
         end else begin
            yuv_out_d = v_q;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         phase_q     <= 2'd0;
         mode_q      <= 1'b0;
         pend_q      <= 1'b0;
         u_q         <= 8'd0;
         v_q         <= 8'd0;
         y0_q        <= 8'd0;
         out_valid_q <= 1'b0;
         rgb_out_q   <= 24'd0;
         yuv_out_q   <= 8'd0;
      end else begin
         phase_q     <= phase_d;
         mode_q      <= mode_d;
         pend_q      <= pend_d;
         u_q         <= u_d;
         v_q         <= v_d;
         y0_q        <= y0_d;
         out_valid_q <= out_valid_d;
         rgb_out_q   <= rgb_out_d;
         yuv_out_q   <= yuv_out_d;
      end
   end

   assign busy      = pend_q & op_mode;
   assign out_valid = out_valid_q;
   assign rgb_out   = rgb_out_q;
   assign yuv_out   = yuv_out_q;

endmodule

// File: tb/tb_cte_color_transform.sv
// Directed vector tables for both modes, reset corner cases, and a gapped random
// mode-0 stream checked against an exact integer model.
module tb_cte_color_transform;

   logic        clk = 1'b0;
   logic        reset;
   logic        op_mode;
   logic        in_en;
   logic [7:0]  yuv_in;
   logic [23:0] rgb_in;
   logic        busy;
   logic        out_valid;
   logic [23:0] rgb_out;
   logic [7:0]  yuv_out;

   cte_color_transform dut (
      .clk       (clk),
      .reset     (reset),
      .op_mode   (op_mode),
      .in_en     (in_en),
      .yuv_in    (yuv_in),
      .rgb_in    (rgb_in),
      .busy      (busy),
      .out_valid (out_valid),
      .rgb_out   (rgb_out),
      .yuv_out   (yuv_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  u, y0, v, y1;
      logic [23:0] p0, p1;
   } m0_vec_t;

   typedef struct {
      logic [23:0] px0, px1;
      logic [7:0]  b0, b1, b2, b3;
   } m1_vec_t;

   int errors = 0;
   int checks = 0;
   int got_n  = 0;
   bit mon_on = 1'b0;
   logic [23:0] expq[$];
   logic [23:0] mon_exp;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic int rdiv(input int n);
      return (n >= 0) ? (n + 500) / 1000 : -((-n + 500) / 1000);
   endfunction

   function automatic logic [7:0] cu8(input int v);
      return (v < 0) ? 8'h00 : (v > 255) ? 8'hFF : 8'(v);
   endfunction

   function automatic logic [23:0] model_rgb(input logic [7:0] yb, input logic [7:0] ub,
                                             input logic [7:0] vb);
      int y, u, v;
      y = int'(yb);
      u = int'($signed(ub));
      v = int'($signed(vb));
      return {cu8(rdiv(1000 * y + 1402 * v)),
              cu8(rdiv(1000 * y - 344 * u - 714 * v)),
              cu8(rdiv(1000 * y + 1772 * u))};
   endfunction

   always @(negedge clk) begin
      if (mon_on && out_valid) begin
         checks++;
         got_n++;
         if (expq.size() == 0) begin
            errors++;
            $display("FAIL stream_extra: got %h expected no pixel", rgb_out);
         end else begin
            mon_exp = expq.pop_front();
            if (rgb_out !== mon_exp) begin
               errors++;
               $display("FAIL stream_pixel %0d: got %h expected %h", got_n, rgb_out, mon_exp);
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

   task automatic run_group(input m0_vec_t t, input string tag);
      @(negedge clk); yuv_in = t.u; in_en = 1'b1;
      @(negedge clk); chk({tag, "_ov_after_u"}, out_valid, 0); yuv_in = t.y0;
      @(negedge clk); chk({tag, "_ov_after_y0"}, out_valid, 0); yuv_in = t.v;
      @(negedge clk); chk({tag, "_ov_after_v"}, out_valid, 1);
                      chk({tag, "_p0"}, rgb_out, t.p0); yuv_in = t.y1;
      @(negedge clk); chk({tag, "_ov_after_y1"}, out_valid, 1);
                      chk({tag, "_p1"}, rgb_out, t.p1); in_en = 1'b0;
      @(negedge clk); chk({tag, "_ov_idle"}, out_valid, 0);
                      chk({tag, "_hold"}, rgb_out, t.p1);
   endtask

   task automatic run_pair(input m1_vec_t t, input string tag);
      @(negedge clk); chk({tag, "_busy_pre"}, busy, 0); rgb_in = t.px0; in_en = 1'b1;
      @(negedge clk); chk({tag, "_b0"}, {out_valid, busy, yuv_out}, {1'b1, 1'b1, t.b0});
                      rgb_in = t.px1;
      @(negedge clk); chk({tag, "_b1"}, {out_valid, busy, yuv_out}, {1'b1, 1'b0, t.b1});
      @(negedge clk); chk({tag, "_b2"}, {out_valid, busy, yuv_out}, {1'b1, 1'b1, t.b2});
                      in_en = 1'b0;
      @(negedge clk); chk({tag, "_b3"}, {out_valid, busy, yuv_out}, {1'b1, 1'b0, t.b3});
      @(negedge clk); chk({tag, "_idle"}, {out_valid, yuv_out}, {1'b0, t.b3});
   endtask

   initial begin
      m0_vec_t m0v[4];
      m1_vec_t m1v[4];
      logic [7:0] b, mu, my0, mv;
      int ph, g;

      m0v[0] = '{8'h00, 8'h80, 8'h00, 8'h40, 24'h808080, 24'h404040};
      m0v[1] = '{8'h7F, 8'hFF, 8'h7F, 8'h00, 24'hFF79FF, 24'hB200E1};
      m0v[2] = '{8'h80, 8'h00, 8'h80, 8'h00, 24'h008700, 24'h008700};
      m0v[3] = '{8'h10, 8'h64, 8'hF0, 8'h20, 24'h4E6A80, 24'h0A263C};

      m1v[0] = '{24'hFFFFFF, 24'h000000, 8'h00, 8'hFF, 8'h00, 8'h00};
      m1v[1] = '{24'hFF0000, 24'h0000FF, 8'hD5, 8'h4C, 8'h7F, 8'h1D};
      m1v[2] = '{24'h808080, 24'h404040, 8'h00, 8'h80, 8'h00, 8'h40};
      m1v[3] = '{24'h00FF00, 24'h102030, 8'hAC, 8'h96, 8'h95, 8'h1D};

      reset = 1'b0; op_mode = 1'b0; in_en = 1'b0; yuv_in = 8'h00; rgb_in = 24'h0;
      #13 reset = 1'b1;
      @(negedge clk);
      chk("reset_state", {busy, out_valid, rgb_out, yuv_out}, 34'h0);

      for (int i = 0; i < 4; i++) run_group(m0v[i], $sformatf("m0v%0d", i));

      // Partial group killed by reset; the next byte must be taken as U.
      @(negedge clk); yuv_in = 8'h7F; in_en = 1'b1;
      @(negedge clk); yuv_in = 8'hFF;
      @(negedge clk); in_en = 1'b0;
      #2 reset = 1'b0;
      #2 reset = 1'b1;
      @(negedge clk);
      chk("midreset_state", {busy, out_valid, rgb_out}, 26'h0);
      run_group(m0v[0], "after_reset");

      mon_on = 1'b1;
      ph = 0; mu = 8'h00; my0 = 8'h00; mv = 8'h00;
      for (int i = 0; i < 1000; i++) begin
         g = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
         repeat (g) begin @(negedge clk); in_en = 1'b0; yuv_in = 8'($urandom_range(0, 255)); end
         @(negedge clk);
         b = 8'($urandom_range(0, 255));
         yuv_in = b; in_en = 1'b1;
         case (ph)
            0: mu = b;
            1: my0 = b;
            2: begin mv = b; expq.push_back(model_rgb(my0, mu, mv)); end
            default: expq.push_back(model_rgb(b, mu, mv));
         endcase
         ph = (ph + 1) % 4;
      end
      @(negedge clk); in_en = 1'b0;
      repeat (4) @(negedge clk);
      mon_on = 1'b0;
      chk("stream_count", got_n, 500);
      chk("stream_leftover", expq.size(), 0);
      run_group(m0v[3], "post_stream");

      @(negedge clk); op_mode = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 4; i++) run_pair(m1v[i], $sformatf("m1v%0d", i));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
